apb2axi_issue_ctrl: RTL and testbench

Issue scheduler between the directory pop port and the transaction manager, clocked on the AXI side.
- Accepts in-order pending requests (tag + direction) and allocates a free AXI ID per direction.
- Caps outstanding writes and reads independently; frees IDs on B / RLAST completions and returns the owning tag.
- Provides a drain handshake so software can quiesce the bridge.

---
 rtl/apb2axi_pkg.sv | 27 ++
 rtl/apb2axi_issue_ctrl_if.sv | 34 +++
 rtl/apb2axi_id_alloc.sv | 97 +++++++++
 rtl/apb2axi_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb2axi_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_pkg.sv
// -----------------------------------------------------------------------------
// apb2axi_pkg
// Shared types and defaults for the APB-to-AXI bridge issue path.
//   issue_state_e      : issue scheduler FSM states
//   issue_req_t        : latched head request (direction + directory tag)
//   ISSUE_MAX_*_OSTD   : default outstanding-transaction caps per direction
//   ISSUE_TAG_W        : tag width carried in issue_req_t; raise it if the
//                        directory ever uses wider tags
// -----------------------------------------------------------------------------
package apb2axi_pkg;

   localparam int ISSUE_MAX_WR_OSTD = 4;
   localparam int ISSUE_MAX_RD_OSTD = 4;
   localparam int ISSUE_TAG_W       = 4;

   typedef enum logic [1:0] {
      ISSUE_IDLE  = 2'd0,
      ISSUE_ISSUE = 2'd1,
      ISSUE_DRAIN = 2'd2
   } issue_state_e;

   typedef struct packed {
      logic                   is_write;
      logic [ISSUE_TAG_W-1:0] tag;
   } issue_req_t;

endpackage

// File: rtl/apb2axi_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// apb2axi_issue_ctrl_if
// Handshake bundle around the issue scheduler:
//   pending_* : directory head request (valid/is_write/tag in, ready out)
//   issue_*   : request towards txn_mgr (valid/is_write/tag/axi_id out, ready in)
// Modports:
//   master : environment side (drives pending request, accepts issues)
//   slave  : the issue scheduler
// -----------------------------------------------------------------------------
interface apb2axi_issue_ctrl_if #(
   parameter int TAG_W    = 4,
   parameter int AXI_ID_W = 4
);
   logic                pending_valid;
   logic                pending_is_write;
   logic [TAG_W-1:0]    pending_tag;
   logic                pending_ready;

   logic                issue_valid;
   logic                issue_is_write;
   logic [TAG_W-1:0]    issue_tag;
   logic [AXI_ID_W-1:0] issue_axi_id;
   logic                issue_ready;

   modport master (
      output pending_valid, pending_is_write, pending_tag, issue_ready,
      input  pending_ready, issue_valid, issue_is_write, issue_tag, issue_axi_id
   );

   modport slave (
      input  pending_valid, pending_is_write, pending_tag, issue_ready,
      output pending_ready, issue_valid, issue_is_write, issue_tag, issue_axi_id
   );
endinterface

// File: rtl/apb2axi_id_alloc.sv
// -----------------------------------------------------------------------------
// apb2axi_id_alloc
// Per-direction AXI ID allocator: in-flight bitmap, lowest-free priority
// encoder, ID->tag table, outstanding count and sticky error flag.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   alloc_en, alloc_tag    : take alloc_id and record its owning tag
//   credit                 : an ID may be allocated this cycle
//   alloc_id               : lowest free ID of the registered bitmap
//   done_valid, done_id    : completion for an ID
//   done_tag               : tag owning done_id (combinational)
//   cnt                    : outstanding count
//   err                    : completion for a non-in-flight ID was seen
// -----------------------------------------------------------------------------
module apb2axi_id_alloc #(
   parameter int ID_W     = 4,
   parameter int TAG_W    = 4,
   parameter int MAX_OSTD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_en,
   input  logic [TAG_W-1:0] alloc_tag,
   output logic             credit,
   output logic [ID_W-1:0]  alloc_id,
   input  logic             done_valid,
   input  logic [ID_W-1:0]  done_id,
   output logic [TAG_W-1:0] done_tag,
   output logic [ID_W:0]    cnt,
   output logic             err
);
   localparam int NUM_IDS = 1 << ID_W;

   logic [NUM_IDS-1:0] bitmap_reg, bitmap_next;
   logic [TAG_W-1:0]   tag_table_reg  [NUM_IDS];
   logic [TAG_W-1:0]   tag_table_next [NUM_IDS];
   logic [ID_W:0]      cnt_reg, cnt_next;
   logic               err_reg;
   logic               has_free;
   logic [ID_W-1:0]    free_id;
   logic               done_hit;

   // Lowest free ID; scanning downwards lets the lowest index win last.
   // Works on the registered bitmap, so an ID freed this cycle is only
   // allocatable from the next cycle on.
   always_comb begin
      has_free = 1'b0;
      free_id  = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (!bitmap_reg[i]) begin
            has_free = 1'b1;
            free_id  = ID_W'(i);
         end
      end
   end

   assign done_hit = done_valid & bitmap_reg[done_id];
   assign credit   = has_free & (cnt_reg < (ID_W+1)'(MAX_OSTD));
   assign alloc_id = free_id;
   assign done_tag = tag_table_reg[done_id];
   assign cnt      = cnt_reg;
   assign err      = err_reg;

   // A slot cannot be set and cleared in the same cycle: set needs the bit
   // clear, a counted completion needs it set.
   generate
      for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_slot
         logic set_bit, clr_bit;
         assign set_bit = alloc_en && (free_id == ID_W'(gi));
         assign clr_bit = done_hit && (done_id == ID_W'(gi));
         assign bitmap_next[gi]    = set_bit | (bitmap_reg[gi] & ~clr_bit);
         assign tag_table_next[gi] = set_bit ? alloc_tag : tag_table_reg[gi];
      end
   endgenerate

   // Accept and completion in the same cycle cancel out.
   assign cnt_next = cnt_reg + (ID_W+1)'(alloc_en) - (ID_W+1)'(done_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_reg <= '0;
         cnt_reg    <= '0;
         err_reg    <= 1'b0;
         for (int i = 0; i < NUM_IDS; i++) begin
            tag_table_reg[i] <= '0;
         end
      end else begin
         bitmap_reg <= bitmap_next;
         cnt_reg    <= cnt_next;
         err_reg    <= err_reg | (done_valid & ~bitmap_reg[done_id]);
         for (int i = 0; i < NUM_IDS; i++) begin
            tag_table_reg[i] <= tag_table_next[i];
         end
      end
   end

endmodule

// File: rtl/apb2axi_issue_ctrl.sv
// -----------------------------------------------------------------------------
// apb2axi_issue_ctrl
// Issue scheduler between the directory pop port and the transaction manager
// (AXI clock domain). Accepts the in-order head request, allocates the lowest
// free AXI ID of its direction, presents it to txn_mgr one cycle later, and
// frees IDs on B / RLAST completions, returning the owning tag.
// Ports:
//   aclk, aresetn              : clock, asynchronous active-low reset
//   bus (slave)                : pending_* head request, issue_* to txn_mgr
//   wr_done_valid/id, wr_done_tag : write completion and owning tag
//   rd_done_valid/id, rd_done_tag : read completion and owning tag
//   wr_ostd_cnt, rd_ostd_cnt   : outstanding counts
//   drain_req, drain_done      : quiesce handshake
//   err_sticky                 : completion for an ID not in flight
//   stall_cycles, issued_cnt   : statistics
// Build option: APB2AXI_ISSUE_STATS_EN enables the statistics counters;
// without it both statistics outputs are constant zero.
// -----------------------------------------------------------------------------
module apb2axi_issue_ctrl
   import apb2axi_pkg::*;
#(
   parameter int AXI_ID_W    = 4,
   parameter int TAG_W       = 4,
   parameter int MAX_WR_OSTD = ISSUE_MAX_WR_OSTD,
   parameter int MAX_RD_OSTD = ISSUE_MAX_RD_OSTD
) (
   input  logic                aclk,
   input  logic                aresetn,
   apb2axi_issue_ctrl_if.slave bus,
   input  logic                wr_done_valid,
   input  logic [AXI_ID_W-1:0] wr_done_id,
   output logic [TAG_W-1:0]    wr_done_tag,
   input  logic                rd_done_valid,
   input  logic [AXI_ID_W-1:0] rd_done_id,
   output logic [TAG_W-1:0]    rd_done_tag,
   output logic [AXI_ID_W:0]   wr_ostd_cnt,
   output logic [AXI_ID_W:0]   rd_ostd_cnt,
   input  logic                drain_req,
   output logic                drain_done,
   output logic                err_sticky,
   output logic [15:0]         stall_cycles,
   output logic [15:0]         issued_cnt
);
   issue_state_e        state_reg, state_next;
   issue_req_t          req_reg;
   logic [AXI_ID_W-1:0] id_reg;

   logic                wr_credit, rd_credit, credit_sel;
   logic [AXI_ID_W-1:0] wr_alloc_id, rd_alloc_id;
   logic                wr_err, rd_err;
   logic                accept;
   logic                pending_ready_c, issue_valid_c, drain_done_c;

   apb2axi_id_alloc #(.ID_W(AXI_ID_W), .TAG_W(TAG_W), .MAX_OSTD(MAX_WR_OSTD)) u_wr_alloc (
      .clk        (aclk),
      .rst_n      (aresetn),
      .alloc_en   (accept & bus.pending_is_write),
      .alloc_tag  (bus.pending_tag),
      .credit     (wr_credit),
      .alloc_id   (wr_alloc_id),
      .done_valid (wr_done_valid),
      .done_id    (wr_done_id),
      .done_tag   (wr_done_tag),
      .cnt        (wr_ostd_cnt),
      .err        (wr_err)
   );

   apb2axi_id_alloc #(.ID_W(AXI_ID_W), .TAG_W(TAG_W), .MAX_OSTD(MAX_RD_OSTD)) u_rd_alloc (
      .clk        (aclk),
      .rst_n      (aresetn),
      .alloc_en   (accept & ~bus.pending_is_write),
      .alloc_tag  (bus.pending_tag),
      .credit     (rd_credit),
      .alloc_id   (rd_alloc_id),
      .done_valid (rd_done_valid),
      .done_id    (rd_done_id),
      .done_tag   (rd_done_tag),
      .cnt        (rd_ostd_cnt),
      .err        (rd_err)
   );

   // Only the head's direction matters: a blocked head blocks everything.
   assign credit_sel = bus.pending_is_write ? wr_credit : rd_credit;
   assign accept     = pending_ready_c;

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_reg <= ISSUE_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ISSUE_IDLE: begin
            if (drain_req)   state_next = ISSUE_DRAIN;
            else if (accept) state_next = ISSUE_ISSUE;
         end
         ISSUE_ISSUE: begin
            if (bus.issue_ready) state_next = drain_req ? ISSUE_DRAIN : ISSUE_IDLE;
         end
         ISSUE_DRAIN: begin
            if (!drain_req) state_next = ISSUE_IDLE;
         end
         default: state_next = ISSUE_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      pending_ready_c = 1'b0;
      issue_valid_c   = 1'b0;
      drain_done_c    = 1'b0;
      case (state_reg)
         ISSUE_IDLE:  pending_ready_c = bus.pending_valid & ~drain_req & credit_sel;
         ISSUE_ISSUE: issue_valid_c   = 1'b1;
         ISSUE_DRAIN: drain_done_c    = (wr_ostd_cnt == '0) && (rd_ostd_cnt == '0);
         default: ;
      endcase
   end

   // Issue payload, captured on accept and held through the ISSUE state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         req_reg <= '0;
         id_reg  <= '0;
      end else if (accept) begin
         req_reg.is_write <= bus.pending_is_write;
         req_reg.tag      <= ISSUE_TAG_W'(bus.pending_tag);
         id_reg           <= bus.pending_is_write ? wr_alloc_id : rd_alloc_id;
      end
   end

   assign bus.pending_ready  = pending_ready_c;
   assign bus.issue_valid    = issue_valid_c;
   assign bus.issue_is_write = req_reg.is_write;
   assign bus.issue_tag      = TAG_W'(req_reg.tag);
   assign bus.issue_axi_id   = id_reg;
   assign drain_done         = drain_done_c;
   assign err_sticky         = wr_err | rd_err;

`ifdef APB2AXI_ISSUE_STATS_EN
   logic [15:0] stall_cycles_reg, issued_cnt_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stall_cycles_reg <= '0;
         issued_cnt_reg   <= '0;
      end else begin
         // Stalls count only while the head is waiting in IDLE.
         if (bus.pending_valid && !pending_ready_c && (state_reg == ISSUE_IDLE)
             && (stall_cycles_reg != 16'hFFFF))
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
         if (issue_valid_c && bus.issue_ready)
            issued_cnt_reg <= issued_cnt_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign issued_cnt   = issued_cnt_reg;
`else
   assign stall_cycles = '0;
   assign issued_cnt   = '0;
`endif

endmodule

// File: tb/tb_apb2axi_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb2axi_issue_ctrl
// Directed bench for apb2axi_issue_ctrl. Stimulus pushes the expected issue
// payload into a queue; a negedge monitor pops and compares on every issue
// handshake. Status outputs are compared inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_apb2axi_issue_ctrl;
   localparam int TAG_W = 4;
   localparam int ID_W  = 4;

   typedef struct packed {
      logic            w;
      logic [TAG_W-1:0] tag;
      logic [ID_W-1:0]  id;
   } exp_t;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             wr_done_valid, rd_done_valid, drain_req;
   logic [ID_W-1:0]  wr_done_id, rd_done_id;
   logic [TAG_W-1:0] wr_done_tag, rd_done_tag;
   logic [ID_W:0]    wr_ostd_cnt, rd_ostd_cnt;
   logic             drain_done, err_sticky;
   logic [15:0]      stall_cycles, issued_cnt;

   int   errors = 0;
   int   checks = 0;
   int   hs_cnt = 0;
   exp_t exp_q[$];
   exp_t mon_got, mon_exp;

   always #5 aclk = ~aclk;

   apb2axi_issue_ctrl_if #(.TAG_W(TAG_W), .AXI_ID_W(ID_W)) bus ();

   apb2axi_issue_ctrl #(.AXI_ID_W(ID_W), .TAG_W(TAG_W), .MAX_WR_OSTD(4), .MAX_RD_OSTD(4)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .bus           (bus.slave),
      .wr_done_valid (wr_done_valid),
      .wr_done_id    (wr_done_id),
      .wr_done_tag   (wr_done_tag),
      .rd_done_valid (rd_done_valid),
      .rd_done_id    (rd_done_id),
      .rd_done_tag   (rd_done_tag),
      .wr_ostd_cnt   (wr_ostd_cnt),
      .rd_ostd_cnt   (rd_ostd_cnt),
      .drain_req     (drain_req),
      .drain_done    (drain_done),
      .err_sticky    (err_sticky),
      .stall_cycles  (stall_cycles),
      .issued_cnt    (issued_cnt)
   );

   // Monitor: every issue handshake must match the head of the scoreboard.
   always @(negedge aclk) begin
      if (aresetn && bus.issue_valid && bus.issue_ready) begin
         mon_got = {bus.issue_is_write, bus.issue_tag, bus.issue_axi_id};
         hs_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got w=%0d tag=%0d id=%0d, required no issue",
                     mon_got.w, mon_got.tag, mon_got.id);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL issue_payload: got w=%0d tag=%0d id=%0d, required w=%0d tag=%0d id=%0d",
                        mon_got.w, mon_got.tag, mon_got.id, mon_exp.w, mon_exp.tag, mon_exp.id);
            end else begin
               $display("issue w=%0d tag=%0d id=%0d ok", mon_got.w, mon_got.tag, mon_got.id);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic mid();
      @(negedge aclk);
   endtask

   // Issue one request and wait (bounded) for accept and the issue handshake.
   task automatic do_req(input logic w, input logic [TAG_W-1:0] tag, input logic [ID_W-1:0] id);
      int n;
      int hs0;
      exp_q.push_back({w, tag, id});
      bus.pending_valid    = 1'b1;
      bus.pending_is_write = w;
      bus.pending_tag      = tag;
      n = 0;
      mid();
      while (!bus.pending_ready && n < 20) begin
         step();
         mid();
         n++;
      end
      check($sformatf("accept tag %0d", tag), 32'(bus.pending_ready), 1);
      if (!bus.pending_ready) begin
         bus.pending_valid = 1'b0;
         void'(exp_q.pop_back());
         return;
      end
      step();
      bus.pending_valid = 1'b0;
      hs0 = hs_cnt;
      n = 0;
      while (hs_cnt == hs0 && n < 20) begin
         step();
         n++;
      end
      check($sformatf("handshake tag %0d", tag), 32'(hs_cnt), 32'(hs0 + 1));
   endtask

   initial begin
      int hs0;
      logic [TAG_W-1:0] wr_tags [4];
      wr_tags[0] = 4'd1; wr_tags[1] = 4'd2; wr_tags[2] = 4'd5; wr_tags[3] = 4'd4;

      bus.pending_valid = 1'b0; bus.pending_is_write = 1'b0; bus.pending_tag = '0;
      bus.issue_ready = 1'b1;
      wr_done_valid = 1'b0; wr_done_id = '0;
      rd_done_valid = 1'b0; rd_done_id = '0;
      drain_req = 1'b0;

      // Reset state
      step(); step();
      aresetn = 1'b1;
      mid();
      check("rst pending_ready", 32'(bus.pending_ready), 0);
      check("rst issue_valid", 32'(bus.issue_valid), 0);
      check("rst wr_ostd_cnt", 32'(wr_ostd_cnt), 0);
      check("rst rd_ostd_cnt", 32'(rd_ostd_cnt), 0);
      check("rst drain_done", 32'(drain_done), 0);
      check("rst err_sticky", 32'(err_sticky), 0);
      check("rst issued_cnt", 32'(issued_cnt), 0);
      step();

      // Single write, tag 3 -> ID 0, then complete it
      do_req(1'b1, 4'd3, 4'd0);
      check("t2 wr_ostd_cnt", 32'(wr_ostd_cnt), 1);
      wr_done_valid = 1'b1; wr_done_id = 4'd0;
      mid();
      check("t2 wr_done_tag", 32'(wr_done_tag), 3);
      step();
      wr_done_valid = 1'b0;
      mid();
      check("t2 wr_ostd_cnt after done", 32'(wr_ostd_cnt), 0);
      step();

      // Five writes against a cap of four
      do_req(1'b1, 4'd1, 4'd0);
      do_req(1'b1, 4'd2, 4'd1);
      do_req(1'b1, 4'd3, 4'd2);
      do_req(1'b1, 4'd4, 4'd3);
      check("t3 wr_ostd_cnt full", 32'(wr_ostd_cnt), 4);
      bus.pending_valid = 1'b1; bus.pending_is_write = 1'b1; bus.pending_tag = 4'd5;
      mid();
      check("t3 5th blocked", 32'(bus.pending_ready), 0);
      step();
      wr_done_valid = 1'b1; wr_done_id = 4'd2;
      mid();
      check("t3 wr_done_tag id2", 32'(wr_done_tag), 3);
      check("t3 blocked during done", 32'(bus.pending_ready), 0);
      step();
      wr_done_valid = 1'b0;
      do_req(1'b1, 4'd5, 4'd2);
`ifdef APB2AXI_ISSUE_STATS_EN
      check("t3 stall_cycles", 32'(stall_cycles), 2);
`endif

      // Back-pressure from txn_mgr
      bus.issue_ready = 1'b0;
      exp_q.push_back({1'b0, 4'd9, 4'd0});
      bus.pending_valid = 1'b1; bus.pending_is_write = 1'b0; bus.pending_tag = 4'd9;
      mid();
      check("t4 accept", 32'(bus.pending_ready), 1);
      step();
      bus.pending_tag = 4'd10;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("t4 issue_valid", 32'(bus.issue_valid), 1);
         check("t4 issue_tag", 32'(bus.issue_tag), 9);
         check("t4 issue_axi_id", 32'(bus.issue_axi_id), 0);
         check("t4 issue_is_write", 32'(bus.issue_is_write), 0);
         check("t4 pending_ready", 32'(bus.pending_ready), 0);
         step();
      end
      bus.issue_ready = 1'b1;
      hs0 = hs_cnt;
      step();
      check("t4 handshake", 32'(hs_cnt), 32'(hs0 + 1));
      do_req(1'b0, 4'd10, 4'd1);

      // Accept and completion in the same cycle, then a spurious completion
      check("t5 err before", 32'(err_sticky), 0);
      exp_q.push_back({1'b0, 4'd11, 4'd2});
      bus.pending_valid = 1'b1; bus.pending_is_write = 1'b0; bus.pending_tag = 4'd11;
      rd_done_valid = 1'b1; rd_done_id = 4'd0;
      mid();
      check("t5 accept", 32'(bus.pending_ready), 1);
      check("t5 rd_done_tag id0", 32'(rd_done_tag), 9);
      hs0 = hs_cnt;
      step();
      bus.pending_valid = 1'b0; rd_done_valid = 1'b0;
      mid();
      check("t5 rd_ostd_cnt", 32'(rd_ostd_cnt), 2);
      step();
      check("t5 handshake", 32'(hs_cnt), 32'(hs0 + 1));
      wr_done_valid = 1'b1; wr_done_id = 4'd7;
      step();
      wr_done_valid = 1'b0;
      mid();
      check("t5 err_sticky", 32'(err_sticky), 1);
      check("t5 wr_ostd_cnt", 32'(wr_ostd_cnt), 4);
      check("t5 rd_ostd_cnt after err", 32'(rd_ostd_cnt), 2);
      step();

      // Retire all writes, then drain with two reads outstanding
      for (int i = 0; i < 4; i++) begin
         wr_done_valid = 1'b1; wr_done_id = ID_W'(i);
         mid();
         check($sformatf("t6 wr_done_tag id%0d", i), 32'(wr_done_tag), 32'(wr_tags[i]));
         step();
      end
      wr_done_valid = 1'b0;
      mid();
      check("t6 wr_ostd_cnt", 32'(wr_ostd_cnt), 0);
      step();
      drain_req = 1'b1;
      bus.pending_valid = 1'b1; bus.pending_is_write = 1'b0; bus.pending_tag = 4'd12;
      mid();
      check("t6 no accept", 32'(bus.pending_ready), 0);
      step();
      mid();
      check("t6 drain_done early", 32'(drain_done), 0);
      step();
      rd_done_valid = 1'b1; rd_done_id = 4'd1;
      mid();
      check("t6 rd_done_tag id1", 32'(rd_done_tag), 10);
      check("t6 drain_done one left", 32'(drain_done), 0);
      step();
      rd_done_id = 4'd2;
      mid();
      check("t6 rd_done_tag id2", 32'(rd_done_tag), 11);
      step();
      rd_done_valid = 1'b0;
      mid();
      check("t6 drain_done", 32'(drain_done), 1);
      check("t6 rd_ostd_cnt", 32'(rd_ostd_cnt), 0);
      check("t6 no accept drained", 32'(bus.pending_ready), 0);
      step();
      drain_req = 1'b0; bus.pending_valid = 1'b0;
      step();
      mid();
      check("t6 drain_done cleared", 32'(drain_done), 0);
      step();
      do_req(1'b0, 4'd12, 4'd0);

      // Reset in the middle of an issue
      bus.pending_valid = 1'b1; bus.pending_is_write = 1'b1; bus.pending_tag = 4'd7;
      mid();
      check("t1 accept", 32'(bus.pending_ready), 1);
      step();
      bus.pending_valid = 1'b0;
      check("t1 issue_valid pre-reset", 32'(bus.issue_valid), 1);
      aresetn = 1'b0;
      #1;
      check("t1 issue_valid reset", 32'(bus.issue_valid), 0);
      check("t1 issue_tag reset", 32'(bus.issue_tag), 0);
      check("t1 wr_ostd_cnt reset", 32'(wr_ostd_cnt), 0);
      check("t1 rd_ostd_cnt reset", 32'(rd_ostd_cnt), 0);
      check("t1 err_sticky reset", 32'(err_sticky), 0);
      check("t1 wr_done_tag reset", 32'(wr_done_tag), 0);
      step();
      aresetn = 1'b1;
      do_req(1'b1, 4'd6, 4'd0);
      do_req(1'b0, 4'd8, 4'd0);
`ifdef APB2AXI_ISSUE_STATS_EN
      check("issued_cnt", 32'(issued_cnt), 2);
`else
      check("stall_cycles tied", 32'(stall_cycles), 0);
      check("issued_cnt tied", 32'(issued_cnt), 0);
`endif
      check("scoreboard empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
